mc_control: RTL and testbench

- Multicycle control FSM for the MIPS core. Sequences the shared datapath through fetch, decode, execute, memory and writeback: one ALU, one unified memory port, and registered IR/A/B/ALUOut/MDR.
- Supported opcodes: R-type, ADDI, ADDIU, LW, SW, BEQ, BNE, J.
- Memory is accessed through a ready handshake with a bounded-wait timeout.

---
 rtl/mc_pkg.sv | 75 +++++++
 rtl/mc_wait_timer.sv | 46 ++++
 rtl/mc_control.sv | 185 ++++++++++++++++++
 tb/tb_mc_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// datapath select codes and the bundle of control lines the FSM drives.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_IMMEX  = 4'd8,
      S_IMMWB  = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_write_cond_n;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       ext_op;
      logic       illegal;
      logic       mem_err;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   function automatic logic is_mem_state(input state_e st);
      return (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
   endfunction

   function automatic logic is_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles spent in a memory state and
// flags the bounded-wait abort when the budget is exhausted.
module mc_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic in_mem_i,
   input  logic ready_i,
   output logic timeout_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_s;

   // Abort only while still waiting; a same-cycle ready always wins.
   always_comb begin
      if ((MEM_TIMEOUT != 32'd0) && in_mem_i && !ready_i && (cnt_q == CNT_W'(MEM_TIMEOUT))) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Held at zero outside memory states so every entry starts a fresh count.
   always_comb begin
      if (!in_mem_i || ready_i || timeout_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1'b1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = timeout_s;

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared datapath with a ready/timeout memory handshake.
module mc_control
   import mc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_opcode,
   input  logic       i_memReady,
   output logic       o_pcWrite,
   output logic       o_pcWriteCond,
   output logic       o_pcWriteCondN,
   output logic       o_iorD,
   output logic       o_memRead,
   output logic       o_memWrite,
   output logic       o_irWrite,
   output logic       o_memToReg,
   output logic       o_regDst,
   output logic       o_regWrite,
   output logic       o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_aluOp,
   output logic [1:0] o_pcSrc,
   output logic       o_extOp,
   output logic       o_illegal,
   output logic       o_memErr,
   output logic [3:0] o_state
);

   state_e     state_q, state_d;
   logic [5:0] opcode_q, opcode_d;
   logic       in_mem_s;
   logic       timeout_s;
   ctrl_t      ctrl_s, ctrl_out_s;

   assign in_mem_s = is_mem_state(state_q);

   mc_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_wait_timer (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .in_mem_i  (in_mem_s),
      .ready_i   (i_memReady),
      .timeout_o (timeout_s)
   );

   // Next-state and opcode latch; later states decode only the latched opcode.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         S_FETCH: begin
            if (i_memReady) state_d = S_DECODE;
            else            state_d = S_FETCH;
         end
         S_DECODE: begin
            opcode_d = i_opcode;
            case (i_opcode)
               OP_LW, OP_SW:      state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXEC;
               OP_ADDI, OP_ADDIU: state_d = S_IMMEX;
               OP_BEQ, OP_BNE:    state_d = S_BRANCH;
               OP_J:              state_d = S_JUMP;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode_q == OP_LW)      state_d = S_MEMRD;
            else if (opcode_q == OP_SW) state_d = S_MEMWR;
            else                        state_d = S_FETCH;
         end
         S_MEMRD: begin
            if (i_memReady)     state_d = S_MEMWB;
            else if (timeout_s) state_d = S_FETCH;
            else                state_d = S_MEMRD;
         end
         S_MEMWR: begin
            if (i_memReady || timeout_s) state_d = S_FETCH;
            else                         state_d = S_MEMWR;
         end
         S_EXEC:  state_d = S_ALUWB;
         S_IMMEX: state_d = S_IMMWB;
         S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   // State and latched-opcode registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_FETCH;
         opcode_q <= 6'd0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   // Control lines decoded from state; FETCH writes and memErr also follow the handshake.
   always_comb begin
      ctrl_s = CTRL_NONE;
      case (state_q)
         S_FETCH: begin
            ctrl_s.mem_read  = 1'b1;
            ctrl_s.alu_src_b = SRCB_FOUR;
            ctrl_s.alu_op    = ALUOP_ADD;
            ctrl_s.pc_src    = PCSRC_ALU;
            ctrl_s.ir_write  = i_memReady;
            ctrl_s.pc_write  = i_memReady;
         end
         S_DECODE: begin
            ctrl_s.alu_src_b = SRCB_IMM_SH2;
            ctrl_s.ext_op    = 1'b1;
            ctrl_s.illegal   = !is_supported(i_opcode);
         end
         S_MEMADR, S_IMMEX: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = SRCB_IMM;
            ctrl_s.ext_op    = 1'b1;
         end
         S_MEMRD: begin
            ctrl_s.mem_read = 1'b1;
            ctrl_s.ior_d    = 1'b1;
         end
         S_MEMWR: begin
            ctrl_s.mem_write = 1'b1;
            ctrl_s.ior_d     = 1'b1;
         end
         S_MEMWB: begin
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.mem_to_reg = 1'b1;
         end
         S_EXEC: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = SRCB_B;
            ctrl_s.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_s.reg_write = 1'b1;
            ctrl_s.reg_dst   = 1'b1;
         end
         S_IMMWB: ctrl_s.reg_write = 1'b1;
         S_BRANCH: begin
            ctrl_s.alu_src_a       = 1'b1;
            ctrl_s.alu_op          = ALUOP_SUB;
            ctrl_s.pc_src          = PCSRC_ALUOUT;
            ctrl_s.pc_write_cond   = (opcode_q == OP_BEQ);
            ctrl_s.pc_write_cond_n = (opcode_q == OP_BNE);
         end
         S_JUMP: begin
            ctrl_s.pc_write = 1'b1;
            ctrl_s.pc_src   = PCSRC_JUMP;
         end
         default: ctrl_s = CTRL_NONE;
      endcase
      ctrl_s.mem_err = timeout_s;
   end

   assign ctrl_out_s = i_rst ? CTRL_NONE : ctrl_s;

   assign o_pcWrite      = ctrl_out_s.pc_write;
   assign o_pcWriteCond  = ctrl_out_s.pc_write_cond;
   assign o_pcWriteCondN = ctrl_out_s.pc_write_cond_n;
   assign o_iorD         = ctrl_out_s.ior_d;
   assign o_memRead      = ctrl_out_s.mem_read;
   assign o_memWrite     = ctrl_out_s.mem_write;
   assign o_irWrite      = ctrl_out_s.ir_write;
   assign o_memToReg     = ctrl_out_s.mem_to_reg;
   assign o_regDst       = ctrl_out_s.reg_dst;
   assign o_regWrite     = ctrl_out_s.reg_write;
   assign o_aluSrcA      = ctrl_out_s.alu_src_a;
   assign o_aluSrcB      = ctrl_out_s.alu_src_b;
   assign o_aluOp        = ctrl_out_s.alu_op;
   assign o_pcSrc        = ctrl_out_s.pc_src;
   assign o_extOp        = ctrl_out_s.ext_op;
   assign o_illegal      = ctrl_out_s.illegal;
   assign o_memErr       = ctrl_out_s.mem_err;
   assign o_state        = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a per-instruction behavioural model
// builds the expected control word for every cycle and one process compares.
module tb_mc_control;
   import mc_pkg::*;

   localparam int T = 16;

   logic       i_clk, i_rst, i_memReady;
   logic [5:0] i_opcode;
   logic       o_pcWrite, o_pcWriteCond, o_pcWriteCondN, o_iorD, o_memRead, o_memWrite;
   logic       o_irWrite, o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_extOp;
   logic       o_illegal, o_memErr;
   logic [1:0] o_aluSrcB, o_aluOp, o_pcSrc;
   logic [3:0] o_state;

   typedef struct packed {
      logic       pcWrite, pcWriteCond, pcWriteCondN, iorD, memRead, memWrite;
      logic       irWrite, memToReg, regDst, regWrite, aluSrcA;
      logic [1:0] aluSrcB, aluOp, pcSrc;
      logic       extOp, illegal, memErr;
      logic [3:0] state;
   } obs_t;

   obs_t  act_s, exp_v;
   logic  exp_valid, lit_go, lit_done;
   string exp_tag;
   int    n_checks, n_fails, err_pulses, ill_pulses, n_lit;
   string lit_name [24];
   int    lit_act  [24];
   int    lit_exp  [24];

   assign act_s = {o_pcWrite, o_pcWriteCond, o_pcWriteCondN, o_iorD, o_memRead, o_memWrite,
                   o_irWrite, o_memToReg, o_regDst, o_regWrite, o_aluSrcA,
                   o_aluSrcB, o_aluOp, o_pcSrc, o_extOp, o_illegal, o_memErr, o_state};

   mc_control #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_memReady(i_memReady),
      .o_pcWrite(o_pcWrite), .o_pcWriteCond(o_pcWriteCond), .o_pcWriteCondN(o_pcWriteCondN),
      .o_iorD(o_iorD), .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_irWrite(o_irWrite),
      .o_memToReg(o_memToReg), .o_regDst(o_regDst), .o_regWrite(o_regWrite),
      .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_aluOp(o_aluOp), .o_pcSrc(o_pcSrc),
      .o_extOp(o_extOp), .o_illegal(o_illegal), .o_memErr(o_memErr), .o_state(o_state)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1);
   end

   // Expected control word for one cycle of a given step, from the control table.
   function automatic obs_t model(input state_e st, input logic [5:0] op, input bit rdy, input bit err);
      obs_t e;
      e        = '0;
      e.state  = st;
      e.memErr = err;
      case (st)
         S_FETCH: begin
            e.memRead = 1'b1; e.aluSrcB = 2'b01; e.irWrite = rdy; e.pcWrite = rdy;
         end
         S_DECODE: begin
            e.aluSrcB = 2'b11; e.extOp = 1'b1;
            e.illegal = !(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h23, 6'h2B});
         end
         S_MEMADR, S_IMMEX: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.extOp = 1'b1; end
         S_MEMRD:  begin e.memRead = 1'b1; e.iorD = 1'b1; end
         S_MEMWR:  begin e.memWrite = 1'b1; e.iorD = 1'b1; end
         S_MEMWB:  begin e.regWrite = 1'b1; e.memToReg = 1'b1; end
         S_EXEC:   begin e.aluSrcA = 1'b1; e.aluOp = 2'b10; end
         S_ALUWB:  begin e.regWrite = 1'b1; e.regDst = 1'b1; end
         S_IMMWB:  e.regWrite = 1'b1;
         S_BRANCH: begin
            e.aluSrcA = 1'b1; e.aluOp = 2'b01; e.pcSrc = 2'b01;
            e.pcWriteCond = (op == 6'h04); e.pcWriteCondN = (op == 6'h05);
         end
         S_JUMP:   begin e.pcWrite = 1'b1; e.pcSrc = 2'b10; end
         default:  e = '0;
      endcase
      return e;
   endfunction

   // Entered just after a rising edge; i_opcode is only meaningful in DECODE.
   task automatic one_cycle(input string tag, input state_e st, input logic [5:0] op, input bit rdy, input bit err);
      i_memReady = rdy;
      i_opcode   = (st == S_DECODE) ? op : ~op;
      exp_v      = model(st, op, rdy, err);
      exp_tag    = tag;
      exp_valid  = 1'b1;
      @(negedge i_clk);
      @(posedge i_clk);
      #1;
   endtask

   // Memory step: ready arrives after w waits unless the counter reaches T first.
   task automatic mem_phase(input string tag, input state_e st, input logic [5:0] op, input int w,
                            output bit ok, inout int cyc);
      ok = 1'b0;
      for (int k = 0; k <= T; k++) begin
         bit rdy, err;
         rdy = (k >= w);
         err = !rdy && (k == T);
         one_cycle(tag, st, op, rdy, err);
         cyc++;
         if (rdy) begin ok = 1'b1; break; end
         if (err) break;
      end
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int mw, output int cyc);
      bit ok;
      cyc = 0;
      mem_phase(tag, S_FETCH, op, fw, ok, cyc);
      if (ok) begin
         one_cycle(tag, S_DECODE, op, 1'b0, 1'b0); cyc++;
         case (op)
            6'h23: begin
               one_cycle(tag, S_MEMADR, op, 1'b0, 1'b0); cyc++;
               mem_phase(tag, S_MEMRD, op, mw, ok, cyc);
               if (ok) begin one_cycle(tag, S_MEMWB, op, 1'b0, 1'b0); cyc++; end
            end
            6'h2B: begin
               one_cycle(tag, S_MEMADR, op, 1'b0, 1'b0); cyc++;
               mem_phase(tag, S_MEMWR, op, mw, ok, cyc);
            end
            6'h00: begin
               one_cycle(tag, S_EXEC, op, 1'b0, 1'b0);  cyc++;
               one_cycle(tag, S_ALUWB, op, 1'b0, 1'b0); cyc++;
            end
            6'h08, 6'h09: begin
               one_cycle(tag, S_IMMEX, op, 1'b0, 1'b0); cyc++;
               one_cycle(tag, S_IMMWB, op, 1'b0, 1'b0); cyc++;
            end
            6'h04, 6'h05: begin one_cycle(tag, S_BRANCH, op, 1'b0, 1'b0); cyc++; end
            6'h02:        begin one_cycle(tag, S_JUMP, op, 1'b0, 1'b0);   cyc++; end
            default: ;
         endcase
      end
   endtask

   task automatic lit(input string name, input int a, input int e);
      lit_name[n_lit] = name;
      lit_act[n_lit]  = a;
      lit_exp[n_lit]  = e;
      n_lit++;
   endtask

   // Reset (async, held for two edges) forces every line low and state to FETCH.
   task automatic reset_cycle(input string tag);
      obs_t r;
      r       = '0;
      r.state = S_FETCH;
      i_rst   = 1'b1;
      #1;
      exp_v     = r;
      exp_tag   = tag;
      exp_valid = 1'b1;
      @(negedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   // The single compare process: per-cycle model check plus the literal pins at the end.
   initial begin : compare_proc
      n_checks = 0; n_fails = 0; err_pulses = 0; ill_pulses = 0; lit_done = 1'b0;
      forever begin
         @(negedge i_clk);
         if (exp_valid) begin
            n_checks++;
            if (o_memErr)  err_pulses++;
            if (o_illegal) ill_pulses++;
            if (act_s !== exp_v) begin
               n_fails++;
               $display("FAIL %s state %0d: got %h expected %h", exp_tag, exp_v.state, act_s, exp_v);
            end
         end
         if (lit_go && !lit_done) begin
            for (int i = 0; i < n_lit; i++) begin
               n_checks++;
               if (lit_act[i] !== lit_exp[i]) begin
                  n_fails++;
                  $display("FAIL %s: got %0d expected %0d", lit_name[i], lit_act[i], lit_exp[i]);
               end
            end
            lit_done = 1'b1;
         end
      end
   end

   initial begin : stimulus
      int c;
      exp_valid  = 1'b0;
      lit_go     = 1'b0;
      n_lit      = 0;
      i_memReady = 1'b0;
      i_opcode   = 6'h00;
      i_rst      = 1'b1;
      @(posedge i_clk);
      #1;
      reset_cycle("reset_init");

      run_instr("rtype",   6'h00, 0, 0, c);   lit("lat_rtype", c, 4);
      run_instr("addi",    6'h08, 0, 0, c);   lit("lat_addi", c, 4);
      run_instr("addiu",   6'h09, 2, 0, c);   lit("lat_addiu_fw2", c, 6);
      run_instr("lw_w3",   6'h23, 0, 3, c);   lit("lat_lw_w3", c, 8);
      run_instr("sw",      6'h2B, 0, 0, c);   lit("lat_sw", c, 4);
      run_instr("bne",     6'h05, 0, 0, c);   lit("lat_bne", c, 3);
      run_instr("beq",     6'h04, 1, 0, c);   lit("lat_beq_fw1", c, 4);
      run_instr("j",       6'h02, 0, 0, c);   lit("lat_j", c, 3);
      run_instr("illegal", 6'h3F, 0, 0, c);   lit("lat_illegal", c, 2);
      lit("illegal_pulses", ill_pulses, 1);
      run_instr("lw_w16",  6'h23, 0, 16, c);  lit("lat_lw_ready_wins", c, 21);
      lit("memerr_before_timeouts", err_pulses, 0);
      run_instr("sw_stuck", 6'h2B, 0, 100, c); lit("lat_sw_timeout", c, 20);
      lit("memerr_after_sw_stuck", err_pulses, 1);
      run_instr("fetch_stuck", 6'h00, 100, 0, c); lit("lat_fetch_timeout", c, 17);
      run_instr("rtype_refetch", 6'h00, 0, 0, c); lit("lat_refetch", c, 4);

      one_cycle("pre_reset_fetch", S_FETCH, 6'h23, 1'b1, 1'b0);
      i_opcode   = 6'h23;
      i_memReady = 1'b1;
      reset_cycle("reset_mid_decode");
      run_instr("j_after_reset", 6'h02, 0, 0, c); lit("lat_j_after_reset", c, 3);

      exp_valid = 1'b0;
      lit("memerr_pulses", err_pulses, 2);
      lit("illegal_total", ill_pulses, 1);
      lit_go = 1'b1;
      for (int i = 0; i < 50 && !lit_done; i++) @(posedge i_clk);
      if (!lit_done) begin
         $display("FAIL lit_phase: got no completion expected completion");
         $fatal(1);
      end
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
